// File: rtl/vu_vmu_pkg.sv
// Shared definitions for the VMU microthread load/AMO path: UT command field
// offsets, issue FSM state encoding and the credit counter width helper.
package vu_vmu_pkg;

    localparam int UTMCMD_VLEN_SZ = 11;
    localparam int TYPE_W         = 4;
    localparam int VLEN_LSB       = 0;
    localparam int TYPE_LSB       = VLEN_LSB + UTMCMD_VLEN_SZ;
    localparam int AMO_BIT        = TYPE_LSB + TYPE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WBCMD = 2'd1,
        ISSUE = 2'd2
    } ut_state_e;

    // A credit counter must hold every value from 0 up to the ROQ depth inclusive.
    function automatic int credit_w(input int entries);
        return $clog2(entries + 1);
    endfunction

endpackage

// File: rtl/vu_vmu_credit_counter.sv
// Up/down credit counter: loads INIT on reset, saturates at INIT on a surplus
// return, and flags nonzero so the issuer can stall at zero credits.
module vu_vmu_credit_counter #(
    parameter int INIT = 8,
    parameter int W    = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         nonzero
);

    localparam logic [W-1:0] MAX = W'(INIT);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && !dec) begin
            if (count_q != MAX) count_d = count_q + 1'b1;
        end else if (dec && !inc) begin
            if (count_q != '0) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= MAX;
        else       count_q <= count_d;
    end

    // A return with every credit already home means the ROQ freed an entry it never had.
    always_ff @(posedge clk) begin
        if (!reset && inc && !dec && count_q == MAX)
            $error("vu_vmu_credit_counter: credit returned while counter is full");
    end

    assign count   = count_q;
    assign nonzero = (count_q != '0);

endmodule

// File: rtl/vu_vmu_ctrl_ut_issue.sv
// VMU UT load/AMO issue controller: accepts a UT command, arms writeback with one
// wbcmd, then issues one tagged request per element gated by ROQ credits.
// Define VMU_UT_AMO_EN to honour the command's amo bit; otherwise it is forced to 0.
module vu_vmu_ctrl_ut_issue
    import vu_vmu_pkg::*;
#(
    parameter int ROQ_ENTRIES = 8,
    parameter int TAG_SZ      = 3,
    parameter int VLEN_SZ     = 11,
    parameter int CMD_SZ      = VLEN_SZ + 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CMD_SZ-1:0] utmcmdq_deq_bits,
    input  logic              utmcmdq_deq_val,
    output logic              utmcmdq_deq_rdy,
    input  logic [31:0]       utaq_deq_bits,
    input  logic              utaq_deq_val,
    output logic              utaq_deq_rdy,
    output logic [31:0]       mem_req_addr,
    output logic [TAG_SZ-1:0] mem_req_tag,
    output logic [3:0]        mem_req_type,
    output logic              mem_req_amo,
    output logic              mem_req_val,
    input  logic              mem_req_rdy,
    output logic [CMD_SZ-1:0] wbcmdq_enq_bits,
    output logic              wbcmdq_enq_val,
    input  logic              wbcmdq_enq_rdy,
    input  logic              roq_free,
    output logic              busy
);

    localparam int CRED_W = credit_w(ROQ_ENTRIES);

    ut_state_e           state_q, state_d;
    logic [CMD_SZ-1:0]   cmd_q, cmd_d;
    logic [VLEN_SZ-1:0]  elem_cnt_q, elem_cnt_d;
    logic [TAG_SZ-1:0]   tag_q, tag_d;
    logic [CRED_W-1:0]   credits;
    logic                credit_nz;
    logic                cmd_acc;
    logic                go;
    logic                fire;
    logic                amo_l;

    assign cmd_acc = (state_q == IDLE) && !reset && utmcmdq_deq_val;
    assign go      = (state_q == ISSUE) && utaq_deq_val && credit_nz;
    assign fire    = go && mem_req_rdy;

    vu_vmu_credit_counter #(
        .INIT (ROQ_ENTRIES),
        .W    (CRED_W)
    ) u_credits (
        .clk     (clk),
        .reset   (reset),
        .inc     (roq_free),
        .dec     (fire),
        .count   (credits),
        .nonzero (credit_nz)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_acc)        state_d = WBCMD;
            WBCMD:   if (wbcmdq_enq_rdy) state_d = ISSUE;
            ISSUE:   if (fire && elem_cnt_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        utmcmdq_deq_rdy = 1'b0;
        wbcmdq_enq_val  = 1'b0;
        wbcmdq_enq_bits = '0;
        mem_req_val     = 1'b0;
        utaq_deq_rdy    = 1'b0;
        mem_req_addr    = '0;
        mem_req_tag     = '0;
        mem_req_type    = '0;
        mem_req_amo     = 1'b0;
        case (state_q)
            IDLE:  utmcmdq_deq_rdy = !reset;
            WBCMD: begin
                wbcmdq_enq_val  = 1'b1;
                wbcmdq_enq_bits = cmd_q;
            end
            ISSUE: begin
                mem_req_val  = go;
                utaq_deq_rdy = fire;
                mem_req_addr = utaq_deq_bits;
                mem_req_tag  = tag_q;
                mem_req_type = cmd_q[TYPE_LSB +: TYPE_W];
                mem_req_amo  = cmd_q[AMO_BIT];
            end
            default: ;
        endcase
        busy = (state_q != IDLE) || (credits != CRED_W'(ROQ_ENTRIES));
    end

`ifdef VMU_UT_AMO_EN
    assign amo_l = utmcmdq_deq_bits[AMO_BIT];
`else
    assign amo_l = 1'b0;
`endif

    // Tag keeps counting across commands so ROQ slot order always equals issue order.
    always_comb begin
        cmd_d      = cmd_q;
        elem_cnt_d = elem_cnt_q;
        tag_d      = tag_q;
        if (cmd_acc) begin
            cmd_d      = {amo_l, utmcmdq_deq_bits[TYPE_LSB +: TYPE_W],
                          utmcmdq_deq_bits[VLEN_LSB +: VLEN_SZ]};
            elem_cnt_d = utmcmdq_deq_bits[VLEN_LSB +: VLEN_SZ];
        end
        if (fire) begin
            tag_d      = tag_q + 1'b1;
            elem_cnt_d = elem_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q      <= '0;
            elem_cnt_q <= '0;
            tag_q      <= '0;
        end else begin
            cmd_q      <= cmd_d;
            elem_cnt_q <= elem_cnt_d;
            tag_q      <= tag_d;
        end
    end

`ifndef VMU_UT_AMO_EN
    always_ff @(posedge clk) begin
        if (cmd_acc && utmcmdq_deq_bits[AMO_BIT])
            $warning("vu_vmu_ctrl_ut_issue: amo command accepted with AMO support disabled, issued as a plain load");
    end
`endif

endmodule

// File: tb/tb_vu_vmu_ctrl_ut_issue.sv
// Randomized scoreboard bench for vu_vmu_ctrl_ut_issue: a transaction-level model
// predicts wbcmds, request order/tags and credit-limited issue cycle by cycle.
`timescale 1ns/1ps
module tb_vu_vmu_ctrl_ut_issue;

    localparam int ROQ     = 8;
    localparam int TAG_SZ  = 3;
    localparam int VLEN_SZ = 11;
    localparam int CMD_SZ  = VLEN_SZ + 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [CMD_SZ-1:0] utmcmdq_deq_bits;
    logic              utmcmdq_deq_val;
    logic              utmcmdq_deq_rdy;
    logic [31:0]       utaq_deq_bits;
    logic              utaq_deq_val;
    logic              utaq_deq_rdy;
    logic [31:0]       mem_req_addr;
    logic [TAG_SZ-1:0] mem_req_tag;
    logic [3:0]        mem_req_type;
    logic              mem_req_amo;
    logic              mem_req_val;
    logic              mem_req_rdy;
    logic [CMD_SZ-1:0] wbcmdq_enq_bits;
    logic              wbcmdq_enq_val;
    logic              wbcmdq_enq_rdy;
    logic              roq_free;
    logic              busy;

    always #5 clk = ~clk;

    vu_vmu_ctrl_ut_issue #(
        .ROQ_ENTRIES (ROQ),
        .TAG_SZ      (TAG_SZ),
        .VLEN_SZ     (VLEN_SZ),
        .CMD_SZ      (CMD_SZ)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .utmcmdq_deq_bits (utmcmdq_deq_bits),
        .utmcmdq_deq_val  (utmcmdq_deq_val),
        .utmcmdq_deq_rdy  (utmcmdq_deq_rdy),
        .utaq_deq_bits    (utaq_deq_bits),
        .utaq_deq_val     (utaq_deq_val),
        .utaq_deq_rdy     (utaq_deq_rdy),
        .mem_req_addr     (mem_req_addr),
        .mem_req_tag      (mem_req_tag),
        .mem_req_type     (mem_req_type),
        .mem_req_amo      (mem_req_amo),
        .mem_req_val      (mem_req_val),
        .mem_req_rdy      (mem_req_rdy),
        .wbcmdq_enq_bits  (wbcmdq_enq_bits),
        .wbcmdq_enq_val   (wbcmdq_enq_val),
        .wbcmdq_enq_rdy   (wbcmdq_enq_rdy),
        .roq_free         (roq_free),
        .busy             (busy)
    );

    typedef struct {
        logic [31:0] addr;
        int          tag;
        logic [3:0]  typ;
        logic        amo;
    } req_t;

    req_t              exp_req[$];
    logic [CMD_SZ-1:0] exp_wb[$];
    int                wb_len[$];
    logic [31:0]       src_addr[$];

    int nvec = 0;
    int nerr = 0;
    int outstanding = 0;
    int issue_left  = 0;
    int tag_ctr     = 0;
    bit m_busy      = 1'b0;
    bit m_wait_wb   = 1'b0;

    int p_cmd, p_utaq, p_mrdy, p_wbrdy, p_free, p_amo, vmax;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: inputs are stable between negedge and the next posedge.
    always @(negedge clk) begin : monitor
        logic  f;
        logic  amo_eff;
        int    n;
        req_t  r;
        logic [31:0] a;
        if (reset) begin
            exp_req.delete(); exp_wb.delete(); wb_len.delete(); src_addr.delete();
            outstanding = 0; issue_left = 0; tag_ctr = 0;
            m_busy = 1'b0; m_wait_wb = 1'b0;
        end else begin
            f = mem_req_val && mem_req_rdy;
            chk("cmd_rdy", utmcmdq_deq_rdy, !m_busy);
            chk("wb_val", wbcmdq_enq_val, m_wait_wb);
            chk("busy", busy, m_busy || outstanding != 0);
            chk("req_val", mem_req_val, issue_left > 0 && utaq_deq_val && outstanding < ROQ);
            chk("utaq_rdy", utaq_deq_rdy, f);

            if (wbcmdq_enq_val && wbcmdq_enq_rdy) begin
                if (exp_wb.size() == 0) begin
                    chk("wb_unexpected", 32'(wbcmdq_enq_val), 32'd0);
                end else begin
                    chk("wb_bits", wbcmdq_enq_bits, exp_wb.pop_front());
                    issue_left = wb_len.pop_front();
                end
                m_wait_wb = 1'b0;
            end

            if (f) begin
                if (exp_req.size() == 0) begin
                    chk("req_unexpected", 32'(f), 32'd0);
                end else begin
                    r = exp_req.pop_front();
                    chk("req_addr", mem_req_addr, r.addr);
                    chk("req_tag", mem_req_tag, r.tag);
                    chk("req_type", mem_req_type, r.typ);
                    chk("req_amo", mem_req_amo, r.amo);
                end
                if (issue_left > 0) issue_left--;
                if (issue_left == 0) m_busy = 1'b0;
            end
            if (utaq_deq_val && utaq_deq_rdy && src_addr.size() > 0) void'(src_addr.pop_front());

            outstanding = outstanding + (f ? 1 : 0) - (roq_free ? 1 : 0);

            if (utmcmdq_deq_val && utmcmdq_deq_rdy) begin
`ifdef VMU_UT_AMO_EN
                amo_eff = utmcmdq_deq_bits[CMD_SZ-1];
`else
                amo_eff = 1'b0;
`endif
                m_busy = 1'b1;
                m_wait_wb = 1'b1;
                n = int'(utmcmdq_deq_bits[VLEN_SZ-1:0]) + 1;
                exp_wb.push_back({amo_eff, utmcmdq_deq_bits[CMD_SZ-2:0]});
                wb_len.push_back(n);
                for (int i = 0; i < n; i++) begin
                    a = $urandom;
                    src_addr.push_back(a);
                    r.addr = a;
                    r.tag  = tag_ctr % ROQ;
                    r.typ  = utmcmdq_deq_bits[VLEN_SZ +: 4];
                    r.amo  = amo_eff;
                    exp_req.push_back(r);
                    tag_ctr++;
                end
            end
        end
    end

    task automatic drive();
        logic       amo;
        logic [3:0] typ;
        logic [10:0] vl;
        amo = ($urandom_range(99) < p_amo);
        typ = 4'($urandom);
        vl  = 11'($urandom_range(vmax));
        utmcmdq_deq_val  = ($urandom_range(99) < p_cmd);
        utmcmdq_deq_bits = {amo, typ, vl};
        utaq_deq_val     = (src_addr.size() > 0) && ($urandom_range(99) < p_utaq);
        utaq_deq_bits    = (src_addr.size() > 0) ? src_addr[0] : $urandom;
        mem_req_rdy      = ($urandom_range(99) < p_mrdy);
        wbcmdq_enq_rdy   = ($urandom_range(99) < p_wbrdy);
        roq_free         = (outstanding > 0) && ($urandom_range(99) < p_free);
    endtask

    task automatic run_phase(input int c, input int u, input int m, input int w,
                             input int fr, input int am, input int vm, input int cycles);
        p_cmd = c; p_utaq = u; p_mrdy = m; p_wbrdy = w; p_free = fr; p_amo = am; vmax = vm;
        repeat (cycles) begin
            @(posedge clk); #1;
            drive();
        end
    endtask

    initial begin
        reset = 1'b1;
        utmcmdq_deq_bits = '0; utmcmdq_deq_val = 1'b0;
        utaq_deq_bits = '0; utaq_deq_val = 1'b0;
        mem_req_rdy = 1'b0; wbcmdq_enq_rdy = 1'b0; roq_free = 1'b0;
        p_cmd = 0; p_utaq = 0; p_mrdy = 0; p_wbrdy = 0; p_free = 0; p_amo = 0; vmax = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        run_phase(100, 100, 100, 100, 100, 0, 3, 200);   // full throughput
        run_phase(100, 100, 100, 100, 100, 30, 0, 60);   // single-element, some amo
        run_phase(60, 70, 60, 50, 40, 5, 12, 600);       // random handshakes
        run_phase(100, 100, 100, 100, 0, 0, 15, 120);    // credits run dry
        run_phase(100, 100, 100, 20, 100, 0, 7, 300);    // wbcmd backpressure
        run_phase(50, 50, 50, 50, 50, 5, 20, 400);

        // Reset in the middle of an issuing command.
        p_cmd = 100; p_utaq = 100; p_mrdy = 100; p_wbrdy = 100; p_free = 0; vmax = 10;
        for (int i = 0; i < 300 && !(issue_left > 2 && outstanding >= 3); i++) begin
            @(posedge clk); #1;
            drive();
        end
        @(posedge clk); #1;
        reset = 1'b1;
        utmcmdq_deq_val = 1'b0; utaq_deq_val = 1'b0; roq_free = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_req_val", mem_req_val, 1'b0);
        chk("post_reset_busy", busy, 1'b0);
        @(posedge clk); #1;

        run_phase(70, 80, 70, 70, 60, 5, 9, 300);

        // Drain everything outstanding.
        p_cmd = 0; p_utaq = 100; p_mrdy = 100; p_wbrdy = 100; p_free = 100;
        for (int i = 0; i < 2000 && (m_busy || outstanding != 0); i++) begin
            @(posedge clk); #1;
            drive();
        end
        @(negedge clk);
        chk("drain_done", {31'd0, m_busy || outstanding != 0}, 32'd0);
        chk("final_busy", busy, 1'b0);
        chk("final_req_queue", exp_req.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
